// File: rtl/controller_hs_pkg.sv
// rtl/controller_hs_pkg.sv - shared types and helpers for the VeriRISC handshake sequencer
package controller_hs_pkg;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
        OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED
    } ctrl_state_t;

    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller_hs_wait_timer.sv
// rtl/controller_hs_wait_timer.sv - saturating wait counter flagging a memory acknowledge timeout
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/controller_hs.sv
// rtl/controller_hs.sv - VeriRISC sequencer with memory acknowledge handshake, timeout and sticky halt
module controller_hs
    import controller_hs_pkg::*;
#(
    parameter bit HANDSHAKE   = 1'b1,
    parameter int MAX_WAIT    = 15,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    input  logic       resume,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic       bus_err,
    output logic [3:0] state_o
);
    ctrl_state_t state_q, state_d;
    logic        bus_err_q, bus_err_d;
    opcode_t     op;
    logic        alu;
    logic        wait_state;
    logic        hold;
    logic        expired;

    assign op  = opcode_t'(opcode);
    assign alu = is_aluop(op);

    assign wait_state = HANDSHAKE &&
                        ((state_q == INST_FETCH) ||
                         ((state_q == OP_FETCH) && alu) ||
                         ((state_q == STORE) && (op == STO)));
    assign hold = wait_state && !mem_ack;

    // Clearing on expiry too keeps the count at zero on entry to HALTED.
    ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (!hold || expired),
        .count_en_i (hold),
        .expired_o  (expired)
    );

    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        if (hold) begin
            if (expired) begin
                state_d   = HALTED;
                bus_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                INST_ADDR:  state_d = INST_FETCH;
                INST_FETCH: state_d = INST_LOAD;
                INST_LOAD:  state_d = IDLE;
                IDLE:       state_d = OP_ADDR;
                OP_ADDR:    state_d = (HALT_STICKY && (op == HLT)) ? HALTED : OP_FETCH;
                OP_FETCH:   state_d = ALU_OP;
                ALU_OP:     state_d = STORE;
                STORE:      state_d = INST_ADDR;
                HALTED:     if (resume && !bus_err_q) state_d = INST_ADDR;
                default:    state_d = INST_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INST_ADDR;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (op == HLT);
            end
            OP_FETCH: mem_rd = alu;
            ALU_OP: begin
                mem_rd  = alu;
                load_ac = alu;
                inc_pc  = (op == SKZ) && zero;
                load_pc = (op == JMP);
            end
            STORE: begin
                mem_rd  = alu;
                load_ac = alu;
                inc_pc  = (op == JMP);
                load_pc = (op == JMP);
                mem_wr  = (op == STO);
            end
            HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule
